// File: rtl/coeff_bank_loader.sv
// Shadow/active coefficient bank for the sectioned ADC linearisation polynomial.
// The host fills the shadow bank word by word, and a commit swaps it in atomically at a sample gap.
// The block also classifies each incoming sample into one of the four polynomial sections.
module coeff_bank_loader #(
    parameter int NUM_SECTIONS = 4,
    parameter int NUM_COEFFS   = 11,
    parameter int COEFF_W      = 32,
    parameter int SAMPLE_W     = 16,
    parameter int MAX_WAIT     = 64
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      wr_valid,
    output logic                                      wr_ready,
    input  logic [1:0]                                wr_section,
    input  logic [3:0]                                wr_index,
    input  logic [COEFF_W-1:0]                        wr_data,
    input  logic                                      commit_req,
    output logic                                      commit_done,
    output logic                                      commit_err,
    output logic                                      addr_err,
    output logic                                      busy,
    input  logic                                      sample_valid,
    input  logic [SAMPLE_W-1:0]                       sample,
    input  logic [SAMPLE_W-1:0]                       section_limit,
    output logic [1:0]                                adc_section,
    output logic                                      section_valid,
    output logic [NUM_SECTIONS*NUM_COEFFS*COEFF_W-1:0] coeff_bank_o
);
    localparam int         TOTAL = NUM_SECTIONS * NUM_COEFFS;
    localparam int         CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [3:0] NC    = 4'(NUM_COEFFS);

    typedef enum logic {LOAD, PEND} state_t;

    state_t                                           state_q, state_d;
    logic [NUM_SECTIONS-1:0][NUM_COEFFS-1:0][COEFF_W-1:0] shadow_q, active_q;
    logic [TOTAL-1:0]                                 mask_q, wr_bit;
    logic [CNT_W-1:0]                                 wait_q;
    logic                                             wr_fire, idx_ok, mask_full;
    logic                                             swap, commit_bad;

    assign wr_fire      = wr_valid && wr_ready;
    assign idx_ok       = wr_index < NC;
    assign coeff_bank_o = active_q;

    // One-hot position of the word being written this cycle.
    always_comb begin
        wr_bit = '0;
        for (int s = 0; s < NUM_SECTIONS; s++)
            for (int k = 0; k < NUM_COEFFS; k++)
                if (wr_fire && idx_ok && wr_section == 2'(s) && wr_index == 4'(k))
                    wr_bit[s*NUM_COEFFS+k] = 1'b1;
    end

    // A write in the same cycle as commit_req counts toward completeness.
    assign mask_full = &(mask_q | wr_bit);

    always_comb begin
        state_d    = state_q;
        wr_ready   = 1'b0;
        busy       = 1'b0;
        swap       = 1'b0;
        commit_bad = 1'b0;
        case (state_q)
            LOAD: begin
                wr_ready = 1'b1;
                if (commit_req) begin
                    if (mask_full) state_d = PEND;
                    else           commit_bad = 1'b1;
                end
            end
            PEND: begin
                busy = 1'b1;
                if (!sample_valid || wait_q == CNT_W'(MAX_WAIT - 1)) begin
                    swap    = 1'b1;
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            shadow_q    <= '0;
            active_q    <= '0;
            mask_q      <= '0;
            wait_q      <= '0;
            commit_done <= 1'b0;
            commit_err  <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= (state_q == PEND) ? wait_q + 1'b1 : '0;
            commit_done <= swap;
            commit_err  <= commit_bad;
            if (swap) begin
                active_q <= shadow_q;
                mask_q   <= '0;
                addr_err <= 1'b0;
            end else begin
                mask_q <= mask_q | wr_bit;
                if (wr_fire && !idx_ok) addr_err <= 1'b1;
            end
            for (int s = 0; s < NUM_SECTIONS; s++)
                for (int k = 0; k < NUM_COEFFS; k++)
                    if (wr_bit[s*NUM_COEFFS+k]) shadow_q[s][k] <= wr_data;
        end
    end

    // |sample| needs one extra bit so that the most negative code stays positive.
    logic [SAMPLE_W:0] mag;
    logic              pos, gt;

    assign mag = sample[SAMPLE_W-1] ? -{sample[SAMPLE_W-1], sample} : {1'b0, sample};
    assign pos = !sample[SAMPLE_W-1] && (|sample);
    assign gt  = mag > {1'b0, section_limit};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            adc_section   <= '0;
            section_valid <= 1'b0;
        end else begin
            section_valid <= sample_valid;
            if (sample_valid) adc_section <= {pos, pos ~^ gt};
        end
    end
endmodule

// File: tb/tb_coeff_bank_loader.sv
// Directed bench for coeff_bank_loader: load/commit sequencing, error flags,
// forced and early swaps, sample classification, and reset during a pending commit.
module tb_coeff_bank_loader;
    localparam int NS  = 4;
    localparam int NCF = 11;
    localparam int CW  = 32;
    localparam int SW  = 16;
    localparam int BW  = NS * NCF * CW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [1:0]    wr_section;
    logic [3:0]    wr_index;
    logic [CW-1:0] wr_data;
    logic          commit_req;
    logic          commit_done;
    logic          commit_err;
    logic          addr_err;
    logic          busy;
    logic          sample_valid;
    logic [SW-1:0] sample;
    logic [SW-1:0] section_limit;
    logic [1:0]    adc_section;
    logic          section_valid;
    logic [BW-1:0] coeff_bank_o;

    int checks   = 0;
    int failures = 0;

    coeff_bank_loader dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_section(wr_section), .wr_index(wr_index), .wr_data(wr_data),
        .commit_req(commit_req), .commit_done(commit_done), .commit_err(commit_err),
        .addr_err(addr_err), .busy(busy), .sample_valid(sample_valid), .sample(sample),
        .section_limit(section_limit), .adc_section(adc_section),
        .section_valid(section_valid), .coeff_bank_o(coeff_bank_o)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are observed 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] bank_word(input int s, input int k);
        return coeff_bank_o[(s*NCF+k)*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] exp_word(input int s, input int k, input int off);
        return CW'(off + (s << 8) + k);
    endfunction

    task automatic write_word(input int s, input int k, input logic [CW-1:0] d);
        wr_valid   = 1'b1;
        wr_section = 2'(s);
        wr_index   = 4'(k);
        wr_data    = d;
        step();
        wr_valid   = 1'b0;
    endtask

    task automatic load_all(input int off);
        for (int s = 0; s < NS; s++)
            for (int k = 0; k < NCF; k++)
                write_word(s, k, exp_word(s, k, off));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (wr_ready !== 1'b1 || busy !== 1'b0 || commit_done !== 1'b0 || commit_err !== 1'b0 ||
            addr_err !== 1'b0 || adc_section !== 2'd0 || section_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got ready=%b busy=%b done=%b err=%b aerr=%b sec=%0d sv=%b, want 1 0 0 0 0 0 0",
                     wr_ready, busy, commit_done, commit_err, addr_err, adc_section, section_valid);
        end
        checks++;
        if (coeff_bank_o !== '0) begin
            failures++;
            $display("FAIL reset_bank: got nonzero bank, want 0");
        end
    endtask

    task automatic test_full_commit();
        load_all(0);
        sample_valid = 1'b0;
        commit_req   = 1'b1;
        step();
        commit_req = 1'b0;
        checks++;
        if (busy !== 1'b1 || wr_ready !== 1'b0 || commit_done !== 1'b0) begin
            failures++;
            $display("FAIL full_pend: got busy=%b ready=%b done=%b, want 1 0 0", busy, wr_ready, commit_done);
        end
        step();
        checks++;
        if (commit_done !== 1'b1 || busy !== 1'b0 || commit_err !== 1'b0) begin
            failures++;
            $display("FAIL full_done: got done=%b busy=%b err=%b, want 1 0 0", commit_done, busy, commit_err);
        end
        checks++;
        if (bank_word(2, 5) !== 32'h205) begin
            failures++;
            $display("FAIL full_word25: got %h, want 00000205", bank_word(2, 5));
        end
        for (int s = 0; s < NS; s++)
            for (int k = 0; k < NCF; k++) begin
                checks++;
                if (bank_word(s, k) !== exp_word(s, k, 0)) begin
                    failures++;
                    $display("FAIL full_bank[%0d][%0d]: got %h, want %h", s, k, bank_word(s, k), exp_word(s, k, 0));
                end
            end
        step();
        checks++;
        if (commit_done !== 1'b0 || commit_err !== 1'b0) begin
            failures++;
            $display("FAIL full_pulse: got done=%b err=%b, want 0 0", commit_done, commit_err);
        end
    endtask

    task automatic test_incomplete();
        do_reset();
        for (int s = 0; s < NS; s++)
            for (int k = 0; k < NCF; k++)
                if (!(s == 3 && k == 10)) write_word(s, k, exp_word(s, k, 'h500));
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        checks++;
        if (commit_err !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL inc_err: got err=%b busy=%b ready=%b, want 1 0 1", commit_err, busy, wr_ready);
        end
        step();
        checks++;
        if (commit_err !== 1'b0 || commit_done !== 1'b0 || coeff_bank_o !== '0) begin
            failures++;
            $display("FAIL inc_after: got err=%b done=%b bank_nonzero=%b, want 0 0 0",
                     commit_err, commit_done, |coeff_bank_o);
        end
        // Final write in the same cycle as commit_req completes the mask.
        wr_valid = 1'b1; wr_section = 2'd3; wr_index = 4'd10; wr_data = exp_word(3, 10, 'h500);
        commit_req = 1'b1;
        step();
        wr_valid = 1'b0; commit_req = 1'b0;
        checks++;
        if (busy !== 1'b1 || commit_err !== 1'b0) begin
            failures++;
            $display("FAIL inc_same_cycle: got busy=%b err=%b, want 1 0", busy, commit_err);
        end
        step();
        checks++;
        if (commit_done !== 1'b1 || bank_word(3, 10) !== exp_word(3, 10, 'h500)) begin
            failures++;
            $display("FAIL inc_swap: got done=%b w310=%h, want 1 %h", commit_done, bank_word(3, 10), exp_word(3, 10, 'h500));
        end
    endtask

    task automatic test_addr_err();
        do_reset();
        write_word(1, 11, 32'hDEAD_BEEF);
        checks++;
        if (addr_err !== 1'b1) begin
            failures++;
            $display("FAIL aerr_set: got %b, want 1", addr_err);
        end
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        checks++;
        if (commit_err !== 1'b1 || addr_err !== 1'b1) begin
            failures++;
            $display("FAIL aerr_nomask: got err=%b aerr=%b, want 1 1", commit_err, addr_err);
        end
        load_all('h300);
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        checks++;
        if (addr_err !== 1'b1) begin
            failures++;
            $display("FAIL aerr_pend: got %b, want 1", addr_err);
        end
        step();
        checks++;
        if (commit_done !== 1'b1 || addr_err !== 1'b0) begin
            failures++;
            $display("FAIL aerr_clear: got done=%b aerr=%b, want 1 0", commit_done, addr_err);
        end
        for (int k = 0; k < NCF; k++) begin
            checks++;
            if (bank_word(1, k) !== exp_word(1, k, 'h300)) begin
                failures++;
                $display("FAIL aerr_bank[1][%0d]: got %h, want %h", k, bank_word(1, k), exp_word(1, k, 'h300));
            end
        end
    endtask

    task automatic test_forced_swap();
        load_all('h1000);
        sample_valid = 1'b1;
        sample       = 16'd5;
        commit_req   = 1'b1;
        step();
        commit_req = 1'b0;
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (busy !== 1'b1 || wr_ready !== 1'b0 || commit_done !== 1'b0) begin
                failures++;
                $display("FAIL forced_busy@%0d: got busy=%b ready=%b done=%b, want 1 0 0", i, busy, wr_ready, commit_done);
            end
            step();
        end
        checks++;
        if (commit_done !== 1'b1 || busy !== 1'b0 || bank_word(2, 5) !== 32'h1205) begin
            failures++;
            $display("FAIL forced_swap: got done=%b busy=%b w25=%h, want 1 0 00001205", commit_done, busy, bank_word(2, 5));
        end
        sample_valid = 1'b0;
        step();
    endtask

    task automatic test_early_gap();
        load_all('h2000);
        sample_valid = 1'b1;
        commit_req   = 1'b1;
        step();
        commit_req = 1'b0;
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (busy !== 1'b1 || commit_done !== 1'b0) begin
                failures++;
                $display("FAIL early_busy@%0d: got busy=%b done=%b, want 1 0", i, busy, commit_done);
            end
            step();
        end
        checks++;
        if (busy !== 1'b1 || bank_word(0, 0) !== 32'h1000) begin
            failures++;
            $display("FAIL early_hold: got busy=%b w00=%h, want 1 00001000", busy, bank_word(0, 0));
        end
        sample_valid = 1'b0;
        step();
        checks++;
        if (commit_done !== 1'b1 || busy !== 1'b0 || bank_word(3, 7) !== 32'h2307) begin
            failures++;
            $display("FAIL early_swap: got done=%b busy=%b w37=%h, want 1 0 00002307", commit_done, busy, bank_word(3, 7));
        end
    endtask

    task automatic test_sections();
        logic [SW-1:0] smp [7];
        logic [1:0]    exp [7];
        smp = '{16'hF830, 16'hFE0C, 16'h0000, 16'h01F4, 16'h03E8, 16'h03E9, 16'h8000};
        exp = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0};
        section_limit = 16'd1000;
        for (int i = 0; i < 7; i++) begin
            sample_valid = 1'b1;
            sample       = smp[i];
            step();
            checks++;
            if (adc_section !== exp[i] || section_valid !== 1'b1) begin
                failures++;
                $display("FAIL section[%0d]: got sec=%0d sv=%b, want %0d 1", i, adc_section, section_valid, exp[i]);
            end
        end
        sample_valid = 1'b0;
        sample       = 16'h0100;
        step();
        checks++;
        if (adc_section !== 2'd0 || section_valid !== 1'b0) begin
            failures++;
            $display("FAIL section_hold: got sec=%0d sv=%b, want 0 0", adc_section, section_valid);
        end
    endtask

    task automatic test_reset_pend();
        load_all('h4000);
        sample_valid = 1'b1;
        commit_req   = 1'b1;
        step();
        commit_req = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL rpend_busy: got %b, want 1", busy);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || wr_ready !== 1'b1 || coeff_bank_o !== '0 || commit_done !== 1'b0) begin
            failures++;
            $display("FAIL rpend_state: got busy=%b ready=%b bank_nonzero=%b done=%b, want 0 1 0 0",
                     busy, wr_ready, |coeff_bank_o, commit_done);
        end
        sample_valid = 1'b0;
        commit_req   = 1'b1;
        step();
        commit_req = 1'b0;
        checks++;
        if (commit_err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rpend_mask: got err=%b busy=%b, want 1 0", commit_err, busy);
        end
    endtask

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_section = '0; wr_index = '0; wr_data = '0;
        commit_req = 1'b0; sample_valid = 1'b0; sample = '0; section_limit = '0;
        test_reset();
        test_full_commit();
        test_incomplete();
        test_addr_err();
        test_forced_swap();
        test_early_gap();
        test_sections();
        test_reset_pend();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
